// File: rtl/spi_response_decoder.sv
// spi_response_decoder
//
// Receive-side companion to the SPI command encoder. It follows the same
// transmit/command request and collects the four bytes the SPI master
// returns for a two-register read: low address, low data, high address,
// high data. The two address-phase bytes are discarded. The data bytes
// are assembled into a raw 16-bit sample {hi, lo}. Each sample is
// announced with a one-cycle data_valid pulse and stored in a six-entry
// bank, indexed by command code.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   transmit     request strobe, sampled only while idle
//   command[2:0] quantity select (0..5 valid, 6/7 rejected)
//   rx_dv        one-cycle strobe: rx_byte is valid
//   rx_byte[7:0] byte returned by the SPI master
//   rd_sel[2:0]  bank read index
//   rd_data      bank entry rd_sel (combinational, 0 for 6/7)
//   data_out     last assembled sample
//   data_cmd     command code belonging to data_out
//   data_valid   one-cycle pulse: data_out/data_cmd updated
//   busy         high while a transaction is in progress
//   cmd_err      one-cycle pulse: invalid command rejected
//   timeout_err  one-cycle pulse: transaction aborted for lack of rx_dv
module spi_response_decoder #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        transmit,
  input  logic [2:0]  command,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  input  logic [2:0]  rd_sel,
  output logic [15:0] rd_data,
  output logic [15:0] data_out,
  output logic [2:0]  data_cmd,
  output logic        data_valid,
  output logic        busy,
  output logic        cmd_err,
  output logic        timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // The counter holds the number of quiet cycles already seen, so a quiet
  // cycle with the counter at TIMEOUT_CYCLES-1 is the one that expires.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LO_ADDR,
    LO_DATA,
    HI_ADDR,
    HI_DATA
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [7:0]       lo_q;
  logic [2:0]       cmd_q;
  logic [15:0]      bank [6];

  logic accept;
  logic reject;
  logic capture_lo;
  logic complete;
  logic expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // An rx_dv always wins over an expiring counter. The counter also
  // returns to zero whenever the state changes, so every waiting state
  // starts its quiet-cycle count fresh.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    accept     = 1'b0;
    reject     = 1'b0;
    capture_lo = 1'b0;
    complete   = 1'b0;
    expire     = 1'b0;
    if (state == IDLE) begin
      if (transmit) begin
        if (command[2:1] == 2'b11) begin
          reject = 1'b1;
        end else begin
          accept     = 1'b1;
          state_next = LO_ADDR;
        end
      end
    end else if (rx_dv) begin
      case (state)
        LO_ADDR: state_next = LO_DATA;
        LO_DATA: begin
          capture_lo = 1'b1;
          state_next = HI_ADDR;
        end
        HI_ADDR: state_next = HI_DATA;
        HI_DATA: begin
          complete   = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (cnt == CNT_LAST) begin
      expire     = 1'b1;
      state_next = IDLE;
    end else begin
      cnt_next = cnt + 1'b1;
    end
  end

  // Datapath and registered status pulses. An aborted transaction drops
  // the half-assembled low byte and leaves the published sample alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q        <= '0;
      cmd_q       <= '0;
      data_out    <= '0;
      data_cmd    <= '0;
      data_valid  <= 1'b0;
      cmd_err     <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        bank[i] <= '0;
      end
    end else begin
      data_valid  <= complete;
      cmd_err     <= reject;
      timeout_err <= expire;
      if (accept) begin
        cmd_q <= command;
      end
      if (capture_lo) begin
        lo_q <= rx_byte;
      end else if (expire) begin
        lo_q <= '0;
      end
      if (complete) begin
        data_out <= {rx_byte, lo_q};
        data_cmd <= cmd_q;
      end
      for (int i = 0; i < 6; i++) begin
        if (complete && (cmd_q == 3'(i))) begin
          bank[i] <= {rx_byte, lo_q};
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 6; i++) begin
      if (rd_sel == 3'(i)) begin
        rd_data = bank[i];
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_response_decoder.sv
// Testbench for spi_response_decoder.
// A transaction-level reference model (bytes received so far, quiet-cycle
// count, expected bank contents) predicts every output once per clock;
// directed scenarios add explicit constant checks on top, followed by a
// randomized phase with varying rx_dv density and occasional resets.
module tb_spi_response_decoder;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        transmit = 1'b0;
  logic [2:0]  command = '0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic [2:0]  rd_sel = '0;
  logic [15:0] rd_data;
  logic [15:0] data_out;
  logic [2:0]  data_cmd;
  logic        data_valid;
  logic        busy;
  logic        cmd_err;
  logic        timeout_err;

  int total = 0;
  int bad = 0;

  // Reference model: a transaction is "active" after an accepted request
  // and needs four bytes; byte #1 (0-based) is the low data, byte #3 the
  // high data. It aborts after TO consecutive quiet cycles.
  logic        mActive;
  int          mBytes;
  int          mQuiet;
  logic [7:0]  mLo;
  logic [2:0]  mCmd;
  logic [15:0] mBank [8];
  logic [15:0] mDataOut;
  logic [2:0]  mDataCmd;
  logic        mValid;
  logic        mCmdErr;
  logic        mTimeout;

  logic [15:0] words [6];

  spi_response_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .transmit    (transmit),
    .command     (command),
    .rx_dv       (rx_dv),
    .rx_byte     (rx_byte),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
    .data_out    (data_out),
    .data_cmd    (data_cmd),
    .data_valid  (data_valid),
    .busy        (busy),
    .cmd_err     (cmd_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mActive  = 1'b0;
    mBytes   = 0;
    mQuiet   = 0;
    mLo      = '0;
    mCmd     = '0;
    mDataOut = '0;
    mDataCmd = '0;
    mValid   = 1'b0;
    mCmdErr  = 1'b0;
    mTimeout = 1'b0;
    for (int i = 0; i < 8; i++) mBank[i] = '0;
  endtask

  task automatic modelStep();
    mValid   = 1'b0;
    mCmdErr  = 1'b0;
    mTimeout = 1'b0;
    if (!mActive) begin
      if (transmit) begin
        if (command < 3'd6) begin
          mActive = 1'b1;
          mCmd    = command;
          mBytes  = 0;
          mQuiet  = 0;
        end else begin
          mCmdErr = 1'b1;
        end
      end
    end else if (rx_dv) begin
      mQuiet = 0;
      if (mBytes == 1) mLo = rx_byte;
      if (mBytes == 3) begin
        mDataOut     = {rx_byte, mLo};
        mDataCmd     = mCmd;
        mBank[mCmd]  = {rx_byte, mLo};
        mValid       = 1'b1;
        mActive      = 1'b0;
      end
      mBytes++;
    end else begin
      mQuiet++;
      if (mQuiet == TO) begin
        mTimeout = 1'b1;
        mActive  = 1'b0;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("busy", busy, mActive);
    checkOutput("data_valid", data_valid, mValid);
    checkOutput("data_out", data_out, mDataOut);
    checkOutput("data_cmd", data_cmd, mDataCmd);
    checkOutput("cmd_err", cmd_err, mCmdErr);
    checkOutput("timeout_err", timeout_err, mTimeout);
    checkOutput("rd_data", rd_data, mBank[rd_sel]);
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  task automatic applyStimulus(input logic tx, input logic [2:0] cmd,
                               input logic dv, input logic [7:0] b);
    transmit = tx;
    command  = cmd;
    rx_dv    = dv;
    rx_byte  = b;
    cycle();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 3'd0, 1'b0, 8'h00);
  endtask

  task automatic sendWord(input logic [2:0] cmd, input logic [7:0] lo,
                          input logic [7:0] hi);
    applyStimulus(1'b1, cmd, 1'b0, 8'h00);
    applyStimulus(1'b0, 3'd0, 1'b1, 8'hFF);
    applyStimulus(1'b0, 3'd0, 1'b1, lo);
    applyStimulus(1'b0, 3'd0, 1'b1, 8'hFF);
    applyStimulus(1'b0, 3'd0, 1'b1, hi);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic assertReset();
    transmit = 1'b0;
    command  = '0;
    rx_dv    = 1'b0;
    rx_byte  = '0;
    rst_n    = 1'b0;
    #1;
    checkOutput("rst_data_out", data_out, 16'h0000);
    checkOutput("rst_data_cmd", data_cmd, 16'h0000);
    checkOutput("rst_valid", data_valid, 16'h0000);
    checkOutput("rst_busy", busy, 16'h0000);
    checkOutput("rst_cmd_err", cmd_err, 16'h0000);
    checkOutput("rst_timeout", timeout_err, 16'h0000);
    checkOutput("rst_rd_data", rd_data, 16'h0000);
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int mode;
    modelReset();
    words = '{16'h0A01, 16'h0B02, 16'h0C03, 16'h0D04, 16'h0E05, 16'h8000};
    #2;
    assertReset();

    // First transaction
    rd_sel = 3'd0;
    sendWord(3'd0, 8'h34, 8'h12);
    checkOutput("first_valid", data_valid, 16'h0001);
    checkOutput("first_word", data_out, 16'h1234);
    checkOutput("first_cmd", data_cmd, 16'h0000);
    checkOutput("first_bank", rd_data, 16'h1234);
    idleCycle();
    checkOutput("first_busy_after", busy, 16'h0000);
    checkOutput("first_valid_after", data_valid, 16'h0000);

    // All six quantities with distinct data
    for (int c = 0; c < 6; c++) begin
      sendWord(3'(c), words[c][7:0], words[c][15:8]);
    end
    for (int s = 0; s < 8; s++) begin
      rd_sel = 3'(s);
      #1;
      checkOutput("bank_readback", rd_data, (s < 6) ? words[s] : 16'h0000);
    end

    // Invalid command
    applyStimulus(1'b1, 3'b110, 1'b0, 8'h00);
    checkOutput("invalid_cmd_err", cmd_err, 16'h0001);
    checkOutput("invalid_busy", busy, 16'h0000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3'd0, 1'b1, 8'h5A);
    idleCycle();

    // Timeout after two bytes
    rd_sel = 3'd2;
    applyStimulus(1'b1, 3'd2, 1'b0, 8'h00);
    applyStimulus(1'b0, 3'd0, 1'b1, 8'hFF);
    applyStimulus(1'b0, 3'd0, 1'b1, 8'hAA);
    for (int i = 0; i < TO - 1; i++) begin
      idleCycle();
      checkOutput("no_early_timeout", timeout_err, 16'h0000);
    end
    idleCycle();
    checkOutput("timeout_pulse", timeout_err, 16'h0001);
    checkOutput("timeout_busy", busy, 16'h0000);
    checkOutput("timeout_data_kept", data_out, 16'h8000);
    checkOutput("timeout_bank_kept", rd_data, 16'h0C03);
    idleCycle();
    checkOutput("timeout_one_cycle", timeout_err, 16'h0000);

    // rx_dv on the expiry cycle wins
    applyStimulus(1'b1, 3'd3, 1'b0, 8'h00);
    applyStimulus(1'b0, 3'd0, 1'b1, 8'hFF);
    applyStimulus(1'b0, 3'd0, 1'b1, 8'h66);
    for (int i = 0; i < TO - 1; i++) idleCycle();
    applyStimulus(1'b0, 3'd0, 1'b1, 8'hFF);
    checkOutput("expiry_rx_no_timeout", timeout_err, 16'h0000);
    checkOutput("expiry_rx_busy", busy, 16'h0001);
    applyStimulus(1'b0, 3'd0, 1'b1, 8'h55);
    checkOutput("expiry_rx_word", data_out, 16'h5566);
    checkOutput("expiry_rx_cmd", data_cmd, 16'h0003);

    // transmit while busy is ignored; transmit in data_valid cycle accepted
    applyStimulus(1'b1, 3'd1, 1'b0, 8'h00);
    applyStimulus(1'b0, 3'd0, 1'b1, 8'hFF);
    applyStimulus(1'b1, 3'd4, 1'b1, 8'h77);
    applyStimulus(1'b0, 3'd0, 1'b1, 8'hFF);
    applyStimulus(1'b0, 3'd0, 1'b1, 8'h99);
    checkOutput("busy_tx_cmd", data_cmd, 16'h0001);
    checkOutput("busy_tx_word", data_out, 16'h9977);
    applyStimulus(1'b1, 3'd5, 1'b0, 8'h00);
    checkOutput("b2b_accept", busy, 16'h0001);
    applyStimulus(1'b0, 3'd0, 1'b1, 8'hFF);
    applyStimulus(1'b0, 3'd0, 1'b1, 8'h01);
    applyStimulus(1'b0, 3'd0, 1'b1, 8'hFF);
    applyStimulus(1'b0, 3'd0, 1'b1, 8'h02);
    checkOutput("b2b_word", data_out, 16'h0201);
    checkOutput("b2b_cmd", data_cmd, 16'h0005);

    // Reset between low and high bytes
    applyStimulus(1'b1, 3'd0, 1'b0, 8'h00);
    applyStimulus(1'b0, 3'd0, 1'b1, 8'hFF);
    applyStimulus(1'b0, 3'd0, 1'b1, 8'h10);
    assertReset();
    sendWord(3'd4, 8'hCD, 8'hAB);
    checkOutput("post_reset_word", data_out, 16'hABCD);
    checkOutput("post_reset_cmd", data_cmd, 16'h0004);

    // Randomized phase
    mode = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 40 == 0) mode = $urandom_range(0, 3);
      rd_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) begin
        assertReset();
      end else begin
        applyStimulus(($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
                      3'($urandom_range(0, 7)),
                      ($urandom_range(0, 99) < ((mode == 0) ? 5 : (mode == 1) ? 50 :
                                                (mode == 2) ? 90 : 100)) ? 1'b1 : 1'b0,
                      8'($urandom_range(0, 255)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_response_decoder.md
# spi_response_decoder

Receive-side companion to the SPI command encoder in the IMU readout path. It accepts the same `transmit`/`command` request the encoder sees and collects the bytes the SPI master returns for the two register reads, low address then high address. It discards the byte shifted in during each address phase and assembles the two data bytes into a signed 16-bit sample. Each completed sample is presented with a one-cycle valid pulse and stored in a six-entry bank, one entry per axis quantity, for random readback.

## Interface
- `TIMEOUT_CYCLES`, default 1024: consecutive cycles without `rx_dv` in a waiting state before the transaction is aborted; must be ≥2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `transmit`  in  1  request strobe, shared with the encoder; sampled only in IDLE.
- `command`  in  3  quantity select, sampled with `transmit`:
  - 000 roll angular, 001 roll linear
  - 010 pitch angular, 011 pitch linear
  - 100 yaw angular, 101 yaw linear
  - 110 and 111 invalid
- `rx_dv`  in  1  one-cycle strobe from the SPI master: `rx_byte` is valid.
- `rx_byte`  in  8  received byte.
- `rd_sel`  in  3  bank read index.
- `rd_data`  out  16  bank entry `rd_sel`, combinational; 0 for index 6 or 7.
- `data_out`  out  16  last assembled sample, `{hi,lo}`, two's complement.
- `data_cmd`  out  3  command code belonging to `data_out`.
- `data_valid`  out  1  one-cycle pulse: `data_out`/`data_cmd` updated.
- `busy`  out  1  high in every state except IDLE.
- `cmd_err`  out  1  one-cycle pulse: invalid command rejected.
- `timeout_err`  out  1  one-cycle pulse: transaction aborted.

## Operation
- FSM states: IDLE, LO_ADDR, LO_DATA, HI_ADDR, HI_DATA.
- IDLE:
  - `transmit` with a valid command: latch `command` into `cmd_q`, then go to LO_ADDR.
  - `transmit` with 110/111: pulse `cmd_err` and stay in IDLE.
  - `rx_dv` in IDLE is ignored.
- LO_ADDR: on `rx_dv`, discard the byte and go to LO_DATA.
- LO_DATA: on `rx_dv`, store the byte in `lo_q` and go to HI_ADDR.
- HI_ADDR: on `rx_dv`, discard the byte and go to HI_DATA.
- HI_DATA: on `rx_dv`, update all of the following on the same edge, then return to IDLE:
  - `data_out <= {rx_byte, lo_q}`
  - `data_cmd <= cmd_q`
  - `bank[cmd_q] <= {rx_byte, lo_q}`
  - `data_valid <= 1`
- `transmit` outside IDLE is ignored; there is no queueing.
- Timeout, in the four waiting states:
  - The counter clears on state entry and on every `rx_dv`, and increments otherwise.
  - When it reaches `TIMEOUT_CYCLES`: pulse `timeout_err`, go to IDLE, leave `data_out`, `data_cmd` and the bank unchanged, discard `lo_q`.
  - Counter width is clog2(`TIMEOUT_CYCLES`+1).
- An `rx_dv` arriving in the same cycle the counter would expire takes priority: the byte is consumed and no timeout occurs.
- Samples are stored raw, with no sign extension or scaling; the high byte is the MSB half.

## Timing
- Reset (async assert, released synchronously by design):
  - state IDLE, counter 0, `lo_q` 0, `cmd_q` 0
  - all bank entries 0
  - `data_out` 0, `data_cmd` 0
  - `data_valid`, `cmd_err`, `timeout_err`, `busy` all 0
- Reset mid-transaction aborts with no pulse and no bank write.
- `busy` rises the cycle after an accepted `transmit`. It falls the cycle after the fourth `rx_dv`, coincident with `data_valid`.
- Latency: `data_valid` is high exactly one cycle, starting the cycle after the fourth `rx_dv`.
- `cmd_err` and `timeout_err` are registered, one cycle wide.
- `rd_data` reflects a bank write in the cycle `data_valid` is high.
- Back-to-back operation: `transmit` in the cycle `data_valid` is high is accepted, since the FSM is already in IDLE.
- `rx_dv` may arrive on consecutive cycles; every strobe advances one state.

## Test plan
- Reset, then `transmit` with `command`=000 and bytes 0xFF, 0x34, 0xFF, 0x12 → one `data_valid` pulse, `data_out`=0x1234, `data_cmd`=000, `rd_sel`=0 gives 0x1234, `busy` low afterwards.
- Cycle all six commands with distinct data (yaw linear: lo 0x00, hi 0x80) → each bank entry holds its own value, entry 5 = 0x8000; `rd_sel`=6/7 → 0.
- `command`=110 → `cmd_err` pulse, `busy` stays 0; subsequent `rx_dv` bytes → no `data_valid`.
- `TIMEOUT_CYCLES`=8, stop after two bytes → `timeout_err` exactly 8 idle cycles after the last `rx_dv`, bank and `data_out` unchanged. Repeat with `rx_dv` landing on the expiry cycle → no timeout, FSM advances.
- `transmit` pulsed while busy with a different command → ignored, completed sample tagged with the original command. Then `transmit` in the `data_valid` cycle → accepted.
- Assert `rst_n` low between the low and high bytes → all outputs 0 immediately; a fresh 4-byte transaction after release completes normally.
